// File: rtl/coffer_pkg.sv
// Shared coffer definitions: hex-to-segment table, keypad debounce states
// and small helpers used by the keypad scanner.
package coffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONFIRM,
      ST_PRESSED,
      ST_RELEASE
   } kp_state_e;

   // Index 15 sits in the MSB slot of the packed array.
   localparam logic [15:0][8:0] SEG_TABLE = {
      9'h071, 9'h079, 9'h05e, 9'h039,
      9'h07c, 9'h077, 9'h06f, 9'h07f,
      9'h007, 9'h07d, 9'h06d, 9'h066,
      9'h04f, 9'h05b, 9'h006, 9'h03f
   };

   function automatic logic [8:0] hex2seg(input logic [3:0] d);
      return SEG_TABLE[d];
   endfunction

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++)
         if (oh[i]) idx = 2'(i);
      return idx;
   endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad header and key-code bundle between the scanner and its consumer.
interface keypad_entry_if;

   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic [8:0] seg_led;

   modport master (
      input  row_in,
      output col_out,
      output key_code,
      output key_valid,
      output key_held,
      output seg_led
   );

   modport slave (
      output row_in,
      input  col_out,
      input  key_code,
      input  key_valid,
      input  key_held,
      input  seg_led
   );

endinterface

// File: rtl/keypad_col_scan.sv
// Row synchronizer, column rotation and per-scan hit aggregation.
// A scan result is SINGLE only when exactly one row/column hit was seen.
module keypad_col_scan
   import coffer_pkg::*;
#(
   parameter int SCAN_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic       o_scan_done,
   output logic       o_scan_single,
   output logic [3:0] o_scan_code
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [SW-1:0] r_slot;
   logic [1:0]    r_col;
   logic [1:0]    r_nhit;
   logic [3:0]    r_code;

   logic       w_last;
   logic [3:0] w_hit;
   logic       w_one;
   logic       w_many;
   logic [1:0] w_tot;
   logic [3:0] w_code;

   assign w_last = (r_slot == SLOT_LAST);
   assign w_hit  = ~r_sync2;
   assign w_one  = (w_hit != 4'd0) && ((w_hit & (w_hit - 4'd1)) == 4'd0);
   assign w_many = (w_hit != 4'd0) && !w_one;

   // Hit count saturates at 2: anything beyond one hit is ghosting.
   always_comb begin
      w_tot = r_nhit;
      if (w_many)
         w_tot = 2'd2;
      else if (w_one && r_nhit != 2'd2)
         w_tot = r_nhit + 2'd1;
   end

   assign w_code = (r_nhit == 2'd1) ? r_code : {oh2idx(w_hit), r_col};

   assign o_col         = ~(4'b0001 << r_col);
   assign o_scan_done   = w_last && (r_col == 2'd3);
   assign o_scan_single = (w_tot == 2'd1);
   assign o_scan_code   = w_code;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 4'hF;
         r_sync2 <= 4'hF;
         r_slot  <= '0;
         r_col   <= 2'd0;
         r_nhit  <= 2'd0;
         r_code  <= 4'd0;
      end else begin
         r_sync1 <= i_row;
         r_sync2 <= r_sync1;
         if (w_last) begin
            r_slot <= '0;
            r_col  <= r_col + 2'd1;
            if (r_col == 2'd3) begin
               r_nhit <= 2'd0;
               r_code <= 4'd0;
            end else begin
               r_nhit <= w_tot;
               r_code <= w_code;
            end
         end else begin
            r_slot <= r_slot + 1'b1;
         end
      end
   end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad entry: scan-level debounce FSM, key-code and display registers.
// One key_valid pulse per accepted press; a new key needs a full release.
module keypad_entry
   import coffer_pkg::*;
#(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic          clk,
   input  logic          reset,
   keypad_entry_if.master kp
);

   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);
   localparam bit ONE_SCAN = (DEBOUNCE_SCANS == 1);

   logic       w_done;
   logic       w_single;
   logic [3:0] w_code;
   logic       w_match;

   logic [CW-1:0] w_cnt_nxt;

   kp_state_e     r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_cand;
   logic [3:0]    r_code;
   logic          r_valid;
   logic          r_held;
   logic [8:0]    r_seg;

   keypad_col_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk           (clk),
      .reset         (reset),
      .i_row         (kp.row_in),
      .o_col         (kp.col_out),
      .o_scan_done   (w_done),
      .o_scan_single (w_single),
      .o_scan_code   (w_code)
   );

   assign w_match   = w_single && (w_code == r_cand);
   assign w_cnt_nxt = r_cnt + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_cand  <= 4'd0;
         r_code  <= 4'd0;
         r_valid <= 1'b0;
         r_held  <= 1'b0;
         r_seg   <= 9'h03f;
      end else begin
         r_valid <= 1'b0;
         if (w_done) begin
            unique case (r_state)
               ST_IDLE: begin
                  if (w_single) begin
                     r_cand <= w_code;
                     if (ONE_SCAN) begin
                        r_state <= ST_PRESSED;
                        r_code  <= w_code;
                        r_seg   <= hex2seg(w_code);
                        r_valid <= 1'b1;
                        r_held  <= 1'b1;
                        r_cnt   <= '0;
                     end else begin
                        r_state <= ST_CONFIRM;
                        r_cnt   <= CW'(1);
                     end
                  end
               end
               ST_CONFIRM: begin
                  if (!w_match) begin
                     r_state <= ST_IDLE;
                     r_cnt   <= '0;
                  end else if (w_cnt_nxt == CNT_DONE) begin
                     r_state <= ST_PRESSED;
                     r_code  <= r_cand;
                     r_seg   <= hex2seg(r_cand);
                     r_valid <= 1'b1;
                     r_held  <= 1'b1;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
               ST_PRESSED: begin
                  if (!w_match) begin
                     if (ONE_SCAN) begin
                        r_state <= ST_IDLE;
                        r_held  <= 1'b0;
                        r_cnt   <= '0;
                     end else begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= CW'(1);
                     end
                  end
               end
               ST_RELEASE: begin
                  // Any key back down returns to PRESSED silently.
                  if (w_single) begin
                     r_state <= ST_PRESSED;
                     r_cnt   <= '0;
                  end else if (w_cnt_nxt == CNT_DONE) begin
                     r_state <= ST_IDLE;
                     r_held  <= 1'b0;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= w_cnt_nxt;
                  end
               end
            endcase
         end
      end
   end

   assign kp.key_code  = r_code;
   assign kp.key_valid = r_valid;
   assign kp.key_held  = r_held;
   assign kp.seg_led   = r_seg;

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized and directed bench for keypad_entry against a scan-level model.
module tb_keypad_entry;

   localparam int SD   = 4;
   localparam int DB   = 3;
   localparam int SCAN = 4 * SD;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   keypad_entry_if kp ();

   keypad_entry #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kp)
   );

   logic [15:0] keys = 16'h0000;

   // Physical keypad: a pressed key pulls its row low while its column is driven.
   always_comb begin
      kp.row_in = 4'hF;
      for (int c = 0; c < 4; c++)
         if (!kp.col_out[c])
            for (int r = 0; r < 4; r++)
               if (keys[r*4+c]) kp.row_in[r] = 1'b0;
   end

   logic [8:0] seg_ref [16] = '{
      9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066, 9'h06d, 9'h07d, 9'h007,
      9'h07f, 9'h06f, 9'h077, 9'h07c, 9'h039, 9'h05e, 9'h079, 9'h071
   };

   int n_total = 0;
   int n_bad   = 0;
   int pulses  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: streak counts of identical scan outcomes.
   bit       m_held;
   bit       m_valid;
   int       m_streak;
   int       m_rel;
   bit [3:0] m_cand;
   bit [3:0] m_code;

   task automatic m_reset();
      m_held = 0; m_valid = 0; m_streak = 0; m_rel = 0;
      m_cand = 0; m_code = 0;
   endtask

   task automatic m_step(input logic [15:0] ks);
      bit       single;
      bit [3:0] k;
      single = ($countones(ks) == 1);
      k = 0;
      for (int i = 0; i < 16; i++)
         if (ks[i]) k = 4'(i);
      m_valid = 0;
      if (!m_held) begin
         if (m_streak > 0)
            m_streak = (single && k == m_cand) ? m_streak + 1 : 0;
         else if (single) begin
            m_cand = k;
            m_streak = 1;
         end
         if (m_streak == DB) begin
            m_held = 1; m_valid = 1; m_code = m_cand;
            m_streak = 0; m_rel = 0;
         end
      end else begin
         if (m_rel == 0) begin
            if (!(single && k == m_cand)) m_rel = 1;
         end else if (single)
            m_rel = 0;
         else
            m_rel++;
         if (m_rel == DB) begin
            m_held = 0; m_rel = 0; m_streak = 0;
         end
      end
   endtask

   task automatic check_cycle(input int slot);
      logic [3:0] col_exp;
      col_exp = ~(4'b0001 << (slot / SD));
      if (kp.key_valid) pulses++;
      chk("col_out", kp.col_out, col_exp);
      chk("key_valid", kp.key_valid, (slot == 0) && m_valid);
      chk("key_code", kp.key_code, m_code);
      chk("key_held", kp.key_held, m_held);
      chk("seg_led", kp.seg_led, seg_ref[m_code]);
   endtask

   // Entered at the negedge of a scan's first cycle; leaves at the next one.
   task automatic run_scan(input logic [15:0] ks);
      keys = ks;
      for (int i = 1; i < SCAN; i++) begin
         @(negedge clk);
         check_cycle(i);
      end
      @(negedge clk);
      m_step(ks);
      check_cycle(0);
   endtask

   task automatic run_n(input logic [15:0] ks, input int n);
      for (int i = 0; i < n; i++) run_scan(ks);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst_col", kp.col_out, 4'b1110);
      chk("rst_valid", kp.key_valid, 1'b0);
      chk("rst_held", kp.key_held, 1'b0);
      chk("rst_code", kp.key_code, 4'd0);
      chk("rst_seg", kp.seg_led, 9'h03f);
      m_reset();
      @(negedge clk);
      reset = 1'b1;
      check_cycle(0);
   endtask

   initial begin
      int p0;
      logic [15:0] ks;
      logic [3:0]  lastk;
      m_reset();
      do_reset();

      // clean press of key 9
      p0 = pulses;
      run_n(16'h0001 << 9, 2);
      chk("press_early", pulses - p0, 0);
      run_scan(16'h0001 << 9);
      chk("press_pulse", pulses - p0, 1);
      run_n(16'h0001 << 9, 3);
      chk("press_once", pulses - p0, 1);
      chk("press_code", kp.key_code, 4'd9);
      chk("press_seg", kp.seg_led, 9'h06f);
      chk("press_held", kp.key_held, 1'b1);
      run_n(16'h0, 4);
      chk("press_rel", kp.key_held, 1'b0);

      // bounce on key 5 then stable
      p0 = pulses;
      foreach (ks[i]) ;
      run_scan(16'h0020); run_scan(16'h0); run_scan(16'h0020);
      run_scan(16'h0020); run_scan(16'h0); run_scan(16'h0020);
      run_scan(16'h0);
      chk("bounce_none", pulses - p0, 0);
      run_n(16'h0020, 4);
      chk("bounce_one", pulses - p0, 1);
      chk("bounce_code", kp.key_code, 4'd5);
      run_n(16'h0, 4);

      // ghosting: keys 0 and 5 together
      p0 = pulses;
      run_n(16'h0021, 5);
      chk("ghost_none", pulses - p0, 0);
      run_n(16'h0020, 5);
      chk("ghost_one", pulses - p0, 1);
      chk("ghost_code", kp.key_code, 4'd5);
      run_n(16'h0, 4);

      // hold and repeat on key 14
      p0 = pulses;
      run_n(16'h4000, 50);
      chk("hold_one", pulses - p0, 1);
      run_n(16'h0, 4);
      chk("hold_drop", kp.key_held, 1'b0);
      run_n(16'h4000, 5);
      chk("hold_two", pulses - p0, 2);
      run_n(16'h0, 4);

      // reset in the middle of debouncing key 3
      p0 = pulses;
      run_n(16'h0008, 2);
      do_reset();
      chk("rstdb_none", pulses - p0, 0);
      run_n(16'h0008, 5);
      chk("rstdb_one", pulses - p0, 1);
      chk("rstdb_code", kp.key_code, 4'd3);
      run_n(16'h0, 4);

      // randomized key activity
      lastk = 4'd0;
      for (int s = 0; s < 40; s++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 3)
            ks = 16'h0;
         else if (sel < 9) begin
            if ($urandom_range(0, 1) == 0)
               lastk = 4'($urandom_range(0, 15));
            ks = 16'h0001 << lastk;
         end else
            ks = (16'h0001 << lastk) |
                 (16'h0001 << 4'($urandom_range(0, 15)));
         run_n(ks, $urandom_range(1, 6));
      end
      run_n(16'h0, 4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
